mips_debug_ctrl: RTL

Debug/loader controller that sequences the MIPS pipeline from a byte-stream host link (UART RX/TX FIFOs). It loads instruction memory, holds the pipeline in reset while loading, and runs it to `halt` or single-steps it. It then dumps the PC and the full register bank back over the TX link. It sits between the UART and the `mips` top, driving the pipeline's reset, its global enable, the IMEM write port and the register-bank debug read port.

---
 rtl/mips_debug_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mips_debug_ctrl.sv
// Host-link debug/loader controller for the MIPS pipeline: loads IMEM, runs or
// single-steps the core, and dumps PC plus the register bank over the TX byte link.
module mips_debug_ctrl #(
    parameter int IMEM_ADDR_W = 8,
    parameter int RUN_TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   cpu_reset,
    output logic                   cpu_en,
    input  logic                   cpu_halt,
    input  logic [31:0]            cpu_pc,
    output logic [4:0]             dbg_reg_addr,
    input  logic [31:0]            dbg_reg_data,
    output logic                   busy
);

    localparam int CNT_W = $clog2(RUN_TIMEOUT + 1);
    localparam logic [7:0] DUMP_LEN = 8'd132;

    typedef enum logic [2:0] {
        IDLE, LD_CNT, LD_BYTE, LD_WRITE, RUN, STEP, ERR, DUMP
    } state_t;

    state_t                 state_q, state_d;
    logic                   cpuReset_q, cpuReset_d;
    logic [IMEM_ADDR_W-1:0] idx_q, idx_d;
    logic [8:0]             wordsLeft_q, wordsLeft_d;
    logic [1:0]             byteCnt_q, byteCnt_d;
    logic [31:0]            asm_q, asm_d;
    logic [CNT_W-1:0]       runCnt_q, runCnt_d;
    logic                   errFromRun_q, errFromRun_d;
    logic                   txValid_q, txValid_d;
    logic [7:0]             txData_q, txData_d;
    logic [7:0]             dumpIdx_q, dumpIdx_d;
    logic [31:0]            dumpShift_q, dumpShift_d;
    logic [5:0]             wordNum;
    logic [31:0]            dumpWord;

    // Dump word 0 is the PC; words 1..32 are registers 0..31.
    assign wordNum      = dumpIdx_q[7:2];
    assign dbg_reg_addr = (wordNum == 6'd0) ? 5'd0 : 5'(wordNum - 6'd1);
    assign dumpWord     = (wordNum == 6'd0) ? cpu_pc : dbg_reg_data;

    assign rx_ready   = (state_q == IDLE) || (state_q == LD_CNT) || (state_q == LD_BYTE);
    assign busy       = (state_q != IDLE);
    assign imem_we    = (state_q == LD_WRITE);
    assign imem_addr  = idx_q;
    assign imem_wdata = asm_q;
    assign cpu_reset  = cpuReset_q;
    assign tx_valid   = txValid_q;
    assign tx_data    = txData_q;

    always_comb begin
        state_d      = state_q;
        cpuReset_d   = cpuReset_q;
        idx_d        = idx_q;
        wordsLeft_d  = wordsLeft_q;
        byteCnt_d    = byteCnt_q;
        asm_d        = asm_q;
        runCnt_d     = runCnt_q;
        errFromRun_d = errFromRun_q;
        txValid_d    = txValid_q;
        txData_d     = txData_q;
        dumpIdx_d    = dumpIdx_q;
        dumpShift_d  = dumpShift_q;
        cpu_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h4C: begin
                            state_d    = LD_CNT;
                            cpuReset_d = 1'b1;
                        end
                        8'h52: begin
                            state_d    = RUN;
                            cpuReset_d = 1'b0;
                            runCnt_d   = '0;
                        end
                        8'h53: begin
                            state_d    = STEP;
                            cpuReset_d = 1'b0;
                        end
                        8'h44:   state_d = DUMP;
                        default: begin
                            state_d      = ERR;
                            errFromRun_d = 1'b0;
                        end
                    endcase
                end
            end
            LD_CNT: begin
                if (rx_valid) begin
                    wordsLeft_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    idx_d       = '0;
                    byteCnt_d   = 2'd0;
                    state_d     = LD_BYTE;
                end
            end
            LD_BYTE: begin
                if (rx_valid) begin
                    asm_d     = {asm_q[23:0], rx_data};
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                idx_d       = idx_q + IMEM_ADDR_W'(1);
                wordsLeft_d = wordsLeft_q - 9'd1;
                state_d     = (wordsLeft_q == 9'd1) ? IDLE : LD_BYTE;
            end
            RUN: begin
                // Halt wins over the timeout and suppresses the enable combinationally.
                if (cpu_halt) begin
                    state_d = DUMP;
                end else begin
                    cpu_en = 1'b1;
                    if (runCnt_q == CNT_W'(RUN_TIMEOUT - 1)) begin
                        state_d      = ERR;
                        errFromRun_d = 1'b1;
                    end else begin
                        runCnt_d = runCnt_q + CNT_W'(1);
                    end
                end
            end
            STEP: begin
                cpu_en  = 1'b1;
                state_d = DUMP;
            end
            ERR: begin
                if (!txValid_q) begin
                    txValid_d = 1'b1;
                    txData_d  = 8'hEE;
                end else if (tx_ready) begin
                    txValid_d    = 1'b0;
                    state_d      = errFromRun_q ? DUMP : IDLE;
                    errFromRun_d = 1'b0;
                end
            end
            DUMP: begin
                // Each word is captured when its first byte is presented, then shifted out.
                if (txValid_q && tx_ready && (dumpIdx_q == DUMP_LEN)) begin
                    txValid_d = 1'b0;
                    dumpIdx_d = 8'd0;
                    state_d   = IDLE;
                end else if ((dumpIdx_q != DUMP_LEN) && (!txValid_q || tx_ready)) begin
                    txValid_d = 1'b1;
                    dumpIdx_d = dumpIdx_q + 8'd1;
                    if (dumpIdx_q[1:0] == 2'd0) begin
                        txData_d    = dumpWord[31:24];
                        dumpShift_d = {dumpWord[23:0], 8'h00};
                    end else begin
                        txData_d    = dumpShift_q[31:24];
                        dumpShift_d = {dumpShift_q[23:0], 8'h00};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cpuReset_q   <= 1'b1;
            idx_q        <= '0;
            wordsLeft_q  <= '0;
            byteCnt_q    <= '0;
            asm_q        <= '0;
            runCnt_q     <= '0;
            errFromRun_q <= 1'b0;
            txValid_q    <= 1'b0;
            txData_q     <= '0;
            dumpIdx_q    <= '0;
            dumpShift_q  <= '0;
        end else begin
            state_q      <= state_d;
            cpuReset_q   <= cpuReset_d;
            idx_q        <= idx_d;
            wordsLeft_q  <= wordsLeft_d;
            byteCnt_q    <= byteCnt_d;
            asm_q        <= asm_d;
            runCnt_q     <= runCnt_d;
            errFromRun_q <= errFromRun_d;
            txValid_q    <= txValid_d;
            txData_q     <= txData_d;
            dumpIdx_q    <= dumpIdx_d;
            dumpShift_q  <= dumpShift_d;
        end
    end

endmodule
